// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch port, data port and backend memory port of the
// instruction/data memory arbiter.
//   master : arbiter side (drives ready/rdata toward the pipeline and
//            req/we/addr/wdata/funct3 toward the memory)
//   slave  : environment side (pipeline requesters plus memory model)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [2:0]        d_funct3;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [2:0]        mem_funct3;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   logic              owner_d;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3,
             mem_rdata, mem_ack,
      output if_rdata, if_ready, d_rdata, d_ready,
             mem_req, mem_we, mem_addr, mem_wdata, mem_funct3, owner_d
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3,
             mem_rdata, mem_ack,
      input  if_rdata, if_ready, d_rdata, d_ready,
             mem_req, mem_we, mem_addr, mem_wdata, mem_funct3, owner_d
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between the instruction-fetch
// port and the load/store port. Data accesses win arbitration, except
// that after STARVE_LIMIT consecutive data grants with a fetch waiting
// the fetch is served. Backend uses a req/ack handshake of arbitrary
// latency; every output is registered.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : master side of mem_port_arbiter_if (fetch, data, memory)
//
// state   | meaning
// IDLE    | no transaction; arbitrate eligible requests
// BUSY_IF | fetch transaction outstanding on memory
// BUSY_D  | data transaction outstanding on memory
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.master bus
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BUSY_IF = 2'd1;
   localparam logic [1:0] BUSY_D  = 2'd2;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [2:0] FUNCT3_LW  = 3'b010;

   logic [1:0]        state;
   logic [3:0]        starve_cnt;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [2:0]        mem_funct3_q;
   logic              if_ready_q;
   logic              d_ready_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              owner_d_q;

   logic              if_elig;
   logic              d_elig;
   logic              grant_d;
   logic              grant_if;

   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_funct3 = mem_funct3_q;
   assign bus.if_ready   = if_ready_q;
   assign bus.d_ready    = d_ready_q;
   assign bus.if_rdata   = if_rdata_q;
   assign bus.d_rdata    = d_rdata_q;
   assign bus.owner_d    = owner_d_q;

   // A port in its ready cycle is not eligible, so a requester that keeps
   // req high through ready is not granted twice for one request.
   always_comb begin
      if_elig  = bus.if_req && !if_ready_q;
      d_elig   = bus.d_req && !d_ready_q;
      grant_d  = d_elig && (!if_elig || (starve_cnt < STARVE_MAX));
      grant_if = if_elig && !grant_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         starve_cnt   <= 4'd0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_funct3_q <= 3'd0;
         if_ready_q   <= 1'b0;
         d_ready_q    <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         owner_d_q    <= 1'b0;
      end else begin
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state        <= BUSY_D;
                  mem_req_q    <= 1'b1;
                  mem_we_q     <= bus.d_we;
                  mem_addr_q   <= bus.d_addr;
                  mem_wdata_q  <= bus.d_wdata;
                  mem_funct3_q <= bus.d_funct3;
                  owner_d_q    <= 1'b1;
                  if (!bus.if_req)
                     starve_cnt <= 4'd0;
                  else if (starve_cnt < STARVE_MAX)
                     starve_cnt <= starve_cnt + 4'd1;
               end else if (grant_if) begin
                  state        <= BUSY_IF;
                  mem_req_q    <= 1'b1;
                  mem_we_q     <= 1'b0;
                  mem_addr_q   <= bus.if_addr;
                  mem_funct3_q <= FUNCT3_LW;
                  owner_d_q    <= 1'b0;
                  starve_cnt   <= 4'd0;
               end
            end
            BUSY_IF: begin
               if (bus.mem_ack) begin
                  state      <= IDLE;
                  mem_req_q  <= 1'b0;
                  mem_we_q   <= 1'b0;
                  if_ready_q <= 1'b1;
                  if_rdata_q <= bus.mem_rdata;
               end
            end
            BUSY_D: begin
               if (bus.mem_ack) begin
                  state     <= IDLE;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  d_ready_q <= 1'b1;
                  owner_d_q <= 1'b0;
                  if (!mem_we_q)
                     d_rdata_q <= bus.mem_rdata;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference.
module tb_mem_port_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference: one outstanding transaction at most; expected outputs
   logic          e_mem_req, e_mem_we, e_if_ready, e_d_ready, e_owner_d;
   logic [AW-1:0] e_mem_addr;
   logic [DW-1:0] e_mem_wdata, e_if_rdata, e_d_rdata;
   logic [2:0]    e_mem_f3;
   bit            m_busy;
   int            m_starve;
   int            busy_cyc;

   int            ack_mode;   // 0 manual, 1 fixed latency, 2 random
   int            ack_lat;
   logic          dut_prev_req;
   bit            grant_log[$];
   int            pulses;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      e_mem_req = 0; e_mem_we = 0; e_if_ready = 0; e_d_ready = 0; e_owner_d = 0;
      e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
      e_mem_f3 = 3'd0; m_busy = 0; m_starve = 0; busy_cyc = 0;
   endtask

   task automatic check_all();
      chk("mem_req",    64'(bus.mem_req),    64'(e_mem_req));
      chk("mem_we",     64'(bus.mem_we),     64'(e_mem_we));
      chk("mem_addr",   64'(bus.mem_addr),   64'(e_mem_addr));
      chk("mem_wdata",  64'(bus.mem_wdata),  64'(e_mem_wdata));
      chk("mem_funct3", 64'(bus.mem_funct3), 64'(e_mem_f3));
      chk("if_ready",   64'(bus.if_ready),   64'(e_if_ready));
      chk("d_ready",    64'(bus.d_ready),    64'(e_d_ready));
      chk("if_rdata",   64'(bus.if_rdata),   64'(e_if_rdata));
      chk("d_rdata",    64'(bus.d_rdata),    64'(e_d_rdata));
      chk("owner_d",    64'(bus.owner_d),    64'(e_owner_d));
   endtask

   // one clock: drive memory response, predict, clock, compare
   task automatic step();
      bit if_el, d_el, ack;
      if (ack_mode == 1)
         bus.mem_ack = e_mem_req && (busy_cyc + 1 >= ack_lat);
      else if (ack_mode == 2) begin
         bus.mem_ack   = ($urandom_range(0, 2) == 0);
         bus.mem_rdata = $urandom;
      end
      ack = bus.mem_ack;
      e_if_ready = 0;
      if (!m_busy) begin
         if_el = bus.if_req && !bus.if_ready;
         d_el  = bus.d_req && !bus.d_ready;
         e_d_ready = 0;
         if (d_el && (!if_el || m_starve < LIM)) begin
            m_busy = 1; e_owner_d = 1; e_mem_req = 1;
            e_mem_we = bus.d_we; e_mem_addr = bus.d_addr;
            e_mem_wdata = bus.d_wdata; e_mem_f3 = bus.d_funct3;
            m_starve = bus.if_req ? ((m_starve >= LIM) ? LIM : m_starve + 1) : 0;
         end else if (if_el) begin
            m_busy = 1; e_owner_d = 0; e_mem_req = 1;
            e_mem_we = 0; e_mem_addr = bus.if_addr; e_mem_f3 = 3'b010;
            m_starve = 0;
         end
         busy_cyc = 0;
      end else begin
         e_d_ready = 0;
         if (ack) begin
            if (e_owner_d) begin
               e_d_ready = 1;
               if (!e_mem_we) e_d_rdata = bus.mem_rdata;
            end else begin
               e_if_ready = 1;
               e_if_rdata = bus.mem_rdata;
            end
            m_busy = 0; e_mem_req = 0; e_mem_we = 0; e_owner_d = 0;
            busy_cyc = 0;
         end else begin
            busy_cyc++;
         end
      end
      @(posedge clk);
      #1;
      if (bus.mem_req && !dut_prev_req) grant_log.push_back(bus.owner_d);
      dut_prev_req = bus.mem_req;
      check_all();
   endtask

   initial begin
      bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
      bus.d_addr = '0; bus.d_wdata = '0; bus.d_funct3 = 3'd0;
      bus.mem_rdata = '0; bus.mem_ack = 0;
      dut_prev_req = 0;
      model_reset();
      ack_mode = 1; ack_lat = 1;
      #3 check_all();
      #19 reset = 1;

      // single fetch, zero-wait
      bus.if_addr = 32'h10; bus.mem_rdata = 32'h00500093; bus.if_req = 1;
      step();
      chk("t1_grant", 64'(bus.mem_req), 64'h1);
      chk("t1_f3", 64'(bus.mem_funct3), 64'h2);
      chk("t1_addr", 64'(bus.mem_addr), 64'h10);
      step();
      chk("t1_ready", 64'(bus.if_ready), 64'h1);
      chk("t1_rdata", 64'(bus.if_rdata), 64'h00500093);
      chk("t1_req_low", 64'(bus.mem_req), 64'h0);
      bus.if_req = 0;
      step();
      chk("t1_single_pulse", 64'(bus.if_ready), 64'h0);

      // simultaneous store and fetch, ack latency 3
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEADBEEF;
      bus.d_funct3 = 3'b010; bus.if_req = 1; bus.if_addr = 32'h20; ack_lat = 3;
      bus.mem_rdata = 32'h11112222;
      step();
      chk("t2_d_first", 64'(bus.owner_d), 64'h1);
      chk("t2_we", 64'(bus.mem_we), 64'h1);
      chk("t2_wdata", 64'(bus.mem_wdata), 64'hDEADBEEF);
      repeat (3) step();
      chk("t2_d_ready", 64'(bus.d_ready), 64'h1);
      chk("t2_d_rdata_kept", 64'(bus.d_rdata), 64'h0);
      chk("t2_idle_gap", 64'(bus.mem_req), 64'h0);
      bus.d_req = 0;
      step();
      chk("t2_if_next", 64'(bus.mem_req), 64'h1);
      chk("t2_if_owner", 64'(bus.owner_d), 64'h0);
      chk("t2_if_addr", 64'(bus.mem_addr), 64'h20);
      repeat (3) step();
      chk("t2_if_ready", 64'(bus.if_ready), 64'h1);
      bus.if_req = 0;
      step();

      // starvation guard: fetch dropped only in data-ready cycles
      ack_lat = 1; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h44;
      bus.if_req = 1; grant_log.delete();
      repeat (28) begin
         step();
         bus.if_req = !e_d_ready;
      end
      chk("t3_grant_count", 64'(grant_log.size() >= 10), 64'h1);
      for (int i = 0; i < 10; i++) begin
         if (i < grant_log.size())
            chk($sformatf("t3_grant%0d", i), 64'(grant_log[i]),
                64'((i == 4 || i == 9) ? 0 : 1));
      end
      bus.d_req = 0; bus.if_req = 0;
      repeat (4) step();

      // wait states on a load, fetch address wiggling meanwhile
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80; bus.d_funct3 = 3'b100;
      bus.mem_rdata = 32'hCAFEF00D; ack_lat = 6; pulses = 0;
      step();
      for (int i = 0; i < 9; i++) begin
         bus.if_addr = $urandom;
         step();
         if (bus.mem_req) chk("t4_addr_stable", 64'(bus.mem_addr), 64'h80);
         if (bus.d_ready) begin
            pulses++;
            chk("t4_rdata", 64'(bus.d_rdata), 64'hCAFEF00D);
            bus.d_req = 0;
         end
      end
      chk("t4_one_pulse", 64'(pulses), 64'h1);

      // reset in the middle of a fetch, then a stray ack
      ack_mode = 0; bus.mem_ack = 0; bus.if_req = 1; bus.if_addr = 32'h30;
      repeat (3) step();
      #2 reset = 0;
      #1 chk("t5_async_drop", 64'(bus.mem_req), 64'h0);
      model_reset();
      check_all();
      bus.if_req = 0; bus.mem_ack = 1;
      @(posedge clk);
      #3 reset = 1;
      dut_prev_req = 0;
      repeat (3) begin
         step();
         chk("t5_no_ready", 64'(bus.if_ready), 64'h0);
         chk("t5_idle", 64'(bus.mem_req), 64'h0);
      end
      bus.mem_ack = 0;

      // requester keeps d_req high through ready with new fields
      ack_mode = 1; ack_lat = 2;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h90;
      for (int i = 0; i < 6 && !e_d_ready; i++) step();
      chk("t6_ready_seen", 64'(bus.d_ready), 64'h1);
      bus.d_addr = 32'h94;
      step();
      chk("t6_no_regrant", 64'(bus.mem_req), 64'h0);
      step();
      chk("t6_regrant", 64'(bus.mem_req), 64'h1);
      chk("t6_new_addr", 64'(bus.mem_addr), 64'h94);
      for (int i = 0; i < 6 && !e_d_ready; i++) step();
      bus.d_req = 0;
      step();

      // random traffic with random acks (including acks while idle)
      ack_mode = 2;
      repeat (600) begin
         bus.if_req   = ($urandom_range(0, 3) != 0);
         bus.d_req    = ($urandom_range(0, 3) != 0);
         bus.d_we     = $urandom_range(0, 1) == 1;
         bus.if_addr  = $urandom;
         bus.d_addr   = $urandom;
         bus.d_wdata  = $urandom;
         bus.d_funct3 = 3'($urandom_range(0, 7));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
